// File: rtl/loader_pkg.sv
// Shared types and constants for the instruction-memory loader.
package loader_pkg;

  typedef enum logic [2:0] {
    LEN_LO,
    LEN_HI,
    PAYLOAD,
    CHECK,
    DONE,
    ERR
  } loader_state_t;

  localparam logic [7:0]  CHK_SEED       = 8'h00;
  localparam int unsigned BYTES_PER_WORD = 4;

endpackage

// File: rtl/word_packer.sv
// Packs accepted bytes little-endian into 32-bit words; word_valid_o fires with the 4th byte.
module word_packer
  import loader_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        clr_i,
  input  logic [7:0]  byte_i,
  input  logic        byte_valid_i,
  output logic [31:0] word_o,
  output logic        word_valid_o
);

  localparam logic [1:0] LastIdx = 2'(BYTES_PER_WORD - 1);

  logic [1:0]  cnt_q, cnt_d;
  logic [23:0] sr_q, sr_d;

  // The 4th byte bypasses the shift register so the word is ready in the same cycle.
  assign word_valid_o = byte_valid_i && (cnt_q == LastIdx);
  assign word_o       = {byte_i, sr_q};

  always_comb begin
    cnt_d = cnt_q;
    sr_d  = sr_q;
    if (clr_i) begin
      cnt_d = '0;
      sr_d  = '0;
    end else if (byte_valid_i) begin
      cnt_d = cnt_q + 2'd1;
      sr_d  = {byte_i, sr_q[23:8]};
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      cnt_q <= '0;
      sr_q  <= '0;
    end else begin
      cnt_q <= cnt_d;
      sr_q  <= sr_d;
    end
  end

endmodule

// File: rtl/instr_mem_loader.sv
// Loads a checksummed byte frame into instruction memory and releases the core on success.
module instr_mem_loader
  import loader_pkg::*;
#(
  parameter int unsigned                ADDRESS_WIDTH = 16,
  parameter int unsigned                DATA_WIDTH    = 32,
  parameter logic [ADDRESS_WIDTH-1:0]   BASE_ADDR     = '0,
  parameter int unsigned                MAX_WORDS     = 1024
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic [7:0]               rx_data,
  input  logic                     rx_valid,
  output logic                     rx_ready,
  output logic                     imem_we,
  output logic [ADDRESS_WIDTH-1:0] imem_addr,
  output logic [DATA_WIDTH-1:0]    imem_wd,
  output logic                     cpu_hold,
  output logic                     done,
  output logic                     error
);

  loader_state_t state_q, state_d;

  logic [7:0]               len_lo_q, len_lo_d;
  logic [15:0]              len_q, len_d;
  logic [15:0]              word_idx_q, word_idx_d;
  logic [7:0]               xor_q, xor_d;
  logic                     imem_we_q, imem_we_d;
  logic [ADDRESS_WIDTH-1:0] imem_addr_q, imem_addr_d;
  logic [DATA_WIDTH-1:0]    imem_wd_q, imem_wd_d;

  logic        accept;
  logic        pack_clr;
  logic        pack_valid;
  logic [31:0] pack_word;
  logic        pack_word_valid;
  logic [15:0] hdr_len;

  assign rx_ready   = (state_q == LEN_LO) || (state_q == LEN_HI) ||
                      (state_q == PAYLOAD) || (state_q == CHECK);
  assign accept     = rx_valid && rx_ready;
  assign hdr_len    = {rx_data, len_lo_q};
  assign pack_valid = accept && (state_q == PAYLOAD);
  // Holding the packer clear outside PAYLOAD guarantees every frame starts on a word boundary.
  assign pack_clr   = (state_q != PAYLOAD);

  word_packer u_word_packer (
    .clk_i        (clk),
    .rst_ni       (rst),
    .clr_i        (pack_clr),
    .byte_i       (rx_data),
    .byte_valid_i (pack_valid),
    .word_o       (pack_word),
    .word_valid_o (pack_word_valid)
  );

  always_comb begin
    state_d     = state_q;
    len_lo_d    = len_lo_q;
    len_d       = len_q;
    word_idx_d  = word_idx_q;
    xor_d       = xor_q;
    imem_we_d   = 1'b0;
    imem_addr_d = imem_addr_q;
    imem_wd_d   = imem_wd_q;

    unique case (state_q)
      LEN_LO: begin
        if (accept) begin
          len_lo_d = rx_data;
          state_d  = LEN_HI;
        end
      end

      LEN_HI: begin
        if (accept) begin
          len_d      = hdr_len;
          word_idx_d = '0;
          xor_d      = CHK_SEED;
          if (hdr_len == 16'd0) begin
            state_d = CHECK;
          end else if (32'(hdr_len) > MAX_WORDS) begin
            state_d = ERR;
          end else begin
            state_d = PAYLOAD;
          end
        end
      end

      PAYLOAD: begin
        if (accept) begin
          xor_d = xor_q ^ rx_data;
        end
        if (pack_word_valid) begin
          imem_we_d   = 1'b1;
          // Address arithmetic wraps at ADDRESS_WIDTH bits.
          imem_addr_d = BASE_ADDR + ADDRESS_WIDTH'({word_idx_q, 2'b00});
          imem_wd_d   = DATA_WIDTH'(pack_word);
          word_idx_d  = word_idx_q + 16'd1;
          if (word_idx_q == len_q - 16'd1) begin
            state_d = CHECK;
          end
        end
      end

      CHECK: begin
        if (accept) begin
          state_d = (rx_data == xor_q) ? DONE : ERR;
        end
      end

      DONE, ERR: begin
        if (start) begin
          state_d    = LEN_LO;
          word_idx_d = '0;
          xor_d      = CHK_SEED;
        end
      end

      default: state_d = LEN_LO;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= LEN_LO;
      len_lo_q    <= '0;
      len_q       <= '0;
      word_idx_q  <= '0;
      xor_q       <= CHK_SEED;
      imem_we_q   <= 1'b0;
      imem_addr_q <= BASE_ADDR;
      imem_wd_q   <= '0;
    end else begin
      state_q     <= state_d;
      len_lo_q    <= len_lo_d;
      len_q       <= len_d;
      word_idx_q  <= word_idx_d;
      xor_q       <= xor_d;
      imem_we_q   <= imem_we_d;
      imem_addr_q <= imem_addr_d;
      imem_wd_q   <= imem_wd_d;
    end
  end

  assign imem_we   = imem_we_q;
  assign imem_addr = imem_addr_q;
  assign imem_wd   = imem_wd_q;
  assign cpu_hold  = (state_q != DONE);
  assign done      = (state_q == DONE);
  assign error     = (state_q == ERR);

endmodule

// File: tb/tb_instr_mem_loader.sv
// Scoreboard bench: stimulus queues expected writes and status snapshots, a monitor compares.
module tb_instr_mem_loader;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic        imem_we;
  logic [15:0] imem_addr;
  logic [31:0] imem_wd;
  logic        cpu_hold;
  logic        done;
  logic        error;

  instr_mem_loader dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .rx_ready  (rx_ready),
    .imem_we   (imem_we),
    .imem_addr (imem_addr),
    .imem_wd   (imem_wd),
    .cpu_hold  (cpu_hold),
    .done      (done),
    .error     (error)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [15:0] addr;
    logic [31:0] data;
  } wr_t;

  // kind: 0 = {done,error,cpu_hold,rx_ready}, 1 = {we,addr,wd}, 2 = write queue drained,
  // 3 = handshake timeout
  typedef struct {
    string       name;
    int          kind;
    logic [3:0]  exp_st;
    logic [48:0] exp_bus;
  } st_t;

  wr_t wq[$];
  st_t sq[$];
  int  checks   = 0;
  int  failures = 0;
  bit  gap      = 1'b0;

  // Monitor: every write pulse must match the oldest expected write; status requests follow.
  always @(negedge clk) begin
    if (imem_we) begin
      checks++;
      if (wq.size() == 0) begin
        failures++;
        $display("FAIL unexpected_write: got addr=%h data=%h, required no write", imem_addr,
                 imem_wd);
      end else begin
        wr_t e;
        e = wq.pop_front();
        if (imem_addr !== e.addr || imem_wd !== e.data) begin
          failures++;
          $display("FAIL write: got addr=%h data=%h, required addr=%h data=%h", imem_addr,
                   imem_wd, e.addr, e.data);
        end
      end
    end
    while (sq.size() > 0) begin
      st_t s;
      s = sq.pop_front();
      checks++;
      case (s.kind)
        0: if ({done, error, cpu_hold, rx_ready} !== s.exp_st) begin
          failures++;
          $display("FAIL %s: got done/error/hold/ready=%b, required %b", s.name,
                   {done, error, cpu_hold, rx_ready}, s.exp_st);
        end
        1: if ({imem_we, imem_addr, imem_wd} !== s.exp_bus) begin
          failures++;
          $display("FAIL %s: got we=%b addr=%h wd=%h, required we=%b addr=%h wd=%h", s.name,
                   imem_we, imem_addr, imem_wd, s.exp_bus[48], s.exp_bus[47:32],
                   s.exp_bus[31:0]);
        end
        2: if (wq.size() != 0) begin
          failures++;
          $display("FAIL %s: got %0d writes still pending, required 0", s.name, wq.size());
        end
        default: begin
          failures++;
          $display("FAIL %s: got rx_ready stuck low, required byte accepted", s.name);
        end
      endcase
    end
  end

  task automatic push_st(input string name, input logic [3:0] exp);
    st_t s;
    s.name = name; s.kind = 0; s.exp_st = exp; s.exp_bus = '0;
    sq.push_back(s);
  endtask

  task automatic push_bus(input string name, input logic [48:0] exp);
    st_t s;
    s.name = name; s.kind = 1; s.exp_st = '0; s.exp_bus = exp;
    sq.push_back(s);
  endtask

  task automatic push_kind(input string name, input int kind);
    st_t s;
    s.name = name; s.kind = kind; s.exp_st = '0; s.exp_bus = '0;
    sq.push_back(s);
  endtask

  task automatic send(input logic [7:0] b);
    bit rdy;
    int n;
    rx_data  = b;
    rx_valid = 1'b1;
    n        = 0;
    do begin
      @(negedge clk);
      rdy = rx_ready;
      @(posedge clk);
      n++;
    end while (!rdy && n < 20);
    #1;
    if (!rdy) begin
      push_kind("byte_timeout", 3);
      rx_valid = 1'b0;
    end
    if (gap) begin
      rx_valid = 1'b0;
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_word(input logic [15:0] addr, input logic [31:0] w);
    wq.push_back({addr, w});
    for (int i = 0; i < 4; i++) send(w[8*i +: 8]);
  endtask

  task automatic idle();
    rx_valid = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic boot_frame(input logic [7:0] chk);
    send(8'h02);
    send(8'h00);
    send_word(16'h0000, 32'h00500093);
    send_word(16'h0004, 32'h00A00113);
    send(chk);
    idle();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no end of stimulus, required completion");
    $fatal(1);
  end

  initial begin
    rst      = 1'b0;
    start    = 1'b0;
    rx_data  = 8'h00;
    rx_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    push_st("reset_status", 4'b0011);
    push_bus("reset_bus", {1'b0, 16'h0000, 32'h0000_0000});
    @(posedge clk);
    #1;
    rst = 1'b1;

    // Boot frame back to back.
    send(8'h02);
    send(8'h00);
    send_word(16'h0000, 32'h00500093);
    send_word(16'h0004, 32'h00A00113);
    push_st("pre_chk", 4'b0011);
    send(8'h71);
    idle();
    push_st("boot_done", 4'b1000);
    push_kind("boot_drain", 2);

    // Same frame, bad checksum.
    pulse_start();
    push_st("rearm_1", 4'b0011);
    boot_frame(8'h8E);
    push_st("bad_chk_err", 4'b0110);
    push_kind("bad_chk_drain", 2);

    // Same frame with rx_valid gaps.
    pulse_start();
    gap = 1'b1;
    boot_frame(8'h71);
    gap = 1'b0;
    push_st("gap_done", 4'b1000);
    push_kind("gap_drain", 2);

    // Oversized word count.
    pulse_start();
    send(8'h01);
    send(8'h04);
    idle();
    push_st("too_long_err", 4'b0110);

    // Empty frame; start mid-header must be ignored.
    pulse_start();
    send(8'h00);
    idle();
    pulse_start();
    push_st("start_ignored", 4'b0011);
    send(8'h00);
    send(8'h00);
    idle();
    push_st("empty_done", 4'b1000);
    pulse_start();
    send(8'h00);
    send(8'h00);
    send(8'h01);
    idle();
    push_st("empty_bad_err", 4'b0110);
    push_kind("empty_drain", 2);

    // Reset mid-frame after 5 payload bytes, then a fresh one-word frame.
    pulse_start();
    send(8'h02);
    send(8'h00);
    send_word(16'h0000, 32'h11223344);
    send(8'hAA);
    idle();
    rst = 1'b0;
    @(posedge clk);
    #1;
    push_bus("midreset_bus", {1'b0, 16'h0000, 32'h0000_0000});
    push_st("midreset_status", 4'b0011);
    @(posedge clk);
    #1;
    rst = 1'b1;
    send(8'h01);
    send(8'h00);
    send_word(16'h0000, 32'hDEADBEEF);
    send(8'h22);
    idle();
    push_st("fresh_done", 4'b1000);
    pulse_start();
    push_st("rearm_hold", 4'b0011);
    push_kind("final_drain", 2);

    repeat (3) @(posedge clk);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
